axi4_sram_slave: RTL and testbench
==================================

# axi4_sram_slave

Parametrised AXI4 slave backed by a byte-writable on-chip SRAM. It terminates the SoC's external AXI4 memory port (AW/W/B/AR/R, ID-tagged, burst-capable) in simulation and FPGA builds. It supersedes fixed 64-bit/16-bit-ID bus termination with configurable data width, ID width, depth and base address. Read and write channels run independent FSMs over one shared array.

## Interface
- DATA_W, 64, data bus width in bits; power of two, 32..256
- ADDR_W, 32, AXI address width
- ID_W, 16, AXI ID width
- DEPTH, 4096, SRAM depth in DATA_W-bit words; power of two
- BASE_ADDR, 32'h8000_0000, byte address of word 0; aligned to DEPTH*DATA_W/8
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- awvalid/awready  in/out  1  write-address handshake
- awaddr  in  ADDR_W; awid  in  ID_W; awlen  in  8; awsize  in  3; awburst  in  2
- wvalid/wready  in/out  1; wdata  in  DATA_W; wstrb  in  DATA_W/8; wlast  in  1
- bvalid/bready  out/in  1; bid  out  ID_W; bresp  out  2
- arvalid/arready  in/out  1; araddr  in  ADDR_W; arid  in  ID_W; arlen  in  8; arsize  in  3; arburst  in  2
- rvalid/rready  out/in  1; rdata  out  DATA_W; rid  out  ID_W; rresp  out  2; rlast  out  1

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. awready=1 only in W_IDLE. On AW handshake, capture id/addr/len/size/burst; clear beat counter and error flag.
- W_DATA: wready=1. Each W handshake writes the wstrb-enabled bytes to the word at (addr-BASE_ADDR)>>log2(DATA_W/8), then advances the address. After beat len, go to W_RESP.
- W_RESP: bvalid=1, bid=captured id. On bready, return to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE. arready=1 only in R_IDLE. On AR handshake, capture fields. Next cycle: rvalid=1 with the first beat.
- On each R handshake: advance the address, load the next beat into the rdata register, and decrement the remaining count.
- rlast=1 on beat arlen. Leave R_DATA after the rlast handshake.
- Address advance:
  - FIXED (2'b00): unchanged.
  - INCR (2'b01): addr + (1<<size).
  - Reserved 2'b11: treated as INCR, flagged as an error.
  - WRAP (2'b10): see Configuration.
- Errors give resp 2'b10 (SLVERR); otherwise resp 2'b00.
  - Write: one flag for the whole burst. Set by any out-of-range beat, size > log2(DATA_W/8), reserved burst, or wlast mismatching the beat count. Out-of-range beats do not write.
  - Read: rresp is per beat. Out-of-range beats return rdata=0. Size/burst errors mark every beat.
- Range: BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8.
- Same-cycle write and read to one word: the read register captures the pre-write data.
- SRAM contents are not reset.

## Timing
- Reset asserted: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0; both FSMs to IDLE.
- awready and arready rise in the first clk edge after reset release.
- Write: AW handshake at cycle N; wready from N+1; last W at M; bvalid at M+1; awready again the cycle after the B handshake.
- Read: AR handshake at N; rvalid at N+1. With rready held high, one beat per cycle, so a len+1 beat burst ends at N+1+len. arready again the cycle after rlast.
- Outputs hold stable while valid is high and ready is low.
- Reset mid-burst aborts immediately. No B or R response is produced for the aborted burst.

## Configuration
- AXI4_SRAM_WRAP_EN defined: WRAP bursts are supported.
  - awlen/arlen must be 1, 3, 7 or 15; otherwise SLVERR and INCR advance.
  - Address wraps within the (len+1)<<size aligned window.
- Not defined: WRAP is treated as INCR and the whole burst responds SLVERR. Writes still occur for in-range beats.

## Test plan
- Reset release, then AW addr=0x8000_0000 len=3 size=3 INCR, four W beats 0x11..0x44 with wstrb=0xFF -> bresp=0, bid echoed. Read back with AR len=3 -> rdata 0x11,0x22,0x33,0x44, rlast on beat 4, rvalid one cycle after the AR handshake.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF, then 0 with wstrb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- R backpressure: rready toggled 1-0-1 -> rdata/rid/rlast stable while stalled, no beat lost or duplicated.
- Out-of-range AR at BASE_ADDR + DEPTH*8 -> rresp=2'b10, rdata=0. AW with awsize=4 at DATA_W=64 -> bresp=2'b10, memory unchanged.
- WRAP at addr=0x8000_0018, len=3, size=3 -> beat addresses 0x18, 0x00, 0x08, 0x10 with AXI4_SRAM_WRAP_EN defined; without it, rresp=2'b10 on all beats.
- rst asserted during a read burst beat 2 of 8 -> rvalid=0 at once; after release a new AR is accepted at first edge and completes normally.

Source files
------------

// File: rtl/axi4_sram_slave.sv
// AXI4 slave terminating a burst-capable memory port onto a byte-writable SRAM.
// Define AXI4_SRAM_WRAP_EN to support WRAP bursts; otherwise they complete as INCR with SLVERR.
module axi4_sram_slave #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 32,
    parameter int                ID_W      = 16,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [ID_W-1:0]     awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [ID_W-1:0]     arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [ID_W-1:0]     rid,
    output logic [1:0]          rresp,
    output logic                rlast
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam longint unsigned MEM_BYTES_L = longint'(DEPTH) * longint'(STRB_W);
    localparam logic [ADDR_W:0] MEM_BYTES = MEM_BYTES_L[ADDR_W:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return {1'b0, off} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return off[OFF_W +: IDX_W];
    endfunction

    function automatic logic wrap_ok(input logic [7:0] len);
        return WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    endfunction

    // Burst-wide error: oversize beats, reserved burst, or a WRAP we cannot honour.
    function automatic logic static_err(input logic [7:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
        return (int'(size) > OFF_W) || (burst == 2'b11) || (burst == 2'b10 && !wrap_ok(len));
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst,
                                                    input logic [7:0] len);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        if (burst == 2'b00)
            return addr;
        else if (burst == 2'b10 && wrap_ok(len))
            return (addr & ~mask) | ((addr + step) & mask);
        else
            return addr + step;
    endfunction

    // ---------------------------------------------------------------- storage
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;

    // NOTE: the array has no reset; clearing it would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[mem_widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- write FSM
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              awready_q, awready_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        mem_widx  = word_idx(w_addr_q);
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    w_id_d    = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_cnt_d   = '0;
                    w_err_d   = static_err(awlen, awsize, awburst);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we    = in_range(w_addr_q) && !(int'(w_size_q) > OFF_W);
                    w_err_d   = w_err_q || !in_range(w_addr_q) ||
                                (wlast != (w_cnt_q == w_len_q));
                    w_addr_d  = next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
                    w_cnt_d   = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
        end
    end

    assign awready = awready_q;
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = w_id_q;
    assign bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------------------------------------------------------- read FSM
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [7:0]        r_rem_q, r_rem_d;
    logic              r_err_q, r_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              arready_q, arready_d;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_err;
    logic              rd_load;

    // The beat register samples the array before any same-edge write lands.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_rem_d   = r_rem_q;
        r_err_d   = r_err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_addr   = r_addr_q;
        rd_err    = r_err_q;
        rd_load   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_id_d    = arid;
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    r_rem_d   = arlen;
                    r_err_d   = static_err(arlen, arsize, arburst);
                    rd_addr   = araddr;
                    rd_err    = r_err_d;
                    rlast_d   = (arlen == 8'd0);
                    rd_load   = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
                        rd_addr  = r_addr_d;
                        r_rem_d  = r_rem_q - 8'd1;
                        rlast_d  = (r_rem_q == 8'd1);
                        rd_load  = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_load) begin
            rdata_d = in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
            rresp_d = (rd_err || !in_range(rd_addr)) ? RESP_SLVERR : RESP_OKAY;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_rem_q   <= '0;
            r_err_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_rem_q   <= r_rem_d;
            r_err_q   <= r_err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = r_id_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: drivers queue expected B/R responses,
// a negedge monitor pops and compares them on every handshake.
module tb_axi4_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [15:0] awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        wvalid = 1'b0, wready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        bvalid, bready = 1'b1;
    logic [15:0] bid;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [15:0] arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid, rready = 1'b1;
    logic [63:0] rdata;
    logic [15:0] rid;
    logic [1:0]  rresp;
    logic        rlast;

    always #5 clk = ~clk;

    axi4_sram_slave dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast)
    );

    typedef struct {
        logic [63:0] data;
        logic [15:0] id;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [15:0] id;
        logic [1:0]  resp;
    } b_exp_t;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] wd [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_r(input logic [63:0] data, input logic [15:0] id,
                          input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.data = data; e.id = id; e.resp = resp; e.last = last;
        exp_r.push_back(e);
    endtask

    // ------------------------------------------------------------ monitor
    r_exp_t      r_e;
    b_exp_t      b_e;
    logic        hold_pend = 1'b0;
    logic [63:0] hold_data;
    logic [15:0] hold_id;
    logic [1:0]  hold_resp;
    logic        hold_last;

    always @(negedge clk) begin
        if (!rst) begin
            hold_pend = 1'b0;
        end else begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL b_extra: got bid 0x%0h, required no response", bid);
                end else begin
                    b_e = exp_b.pop_front();
                    check("bid", {48'd0, bid}, {48'd0, b_e.id});
                    check("bresp", {62'd0, bresp}, {62'd0, b_e.resp});
                end
            end
            if (rvalid && hold_pend) begin
                check("r_hold_data", rdata, hold_data);
                check("r_hold_id", {48'd0, rid}, {48'd0, hold_id});
                check("r_hold_resp", {62'd0, rresp}, {62'd0, hold_resp});
                check("r_hold_last", {63'd0, rlast}, {63'd0, hold_last});
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL r_extra: got rdata 0x%0h, required no beat", rdata);
                end else begin
                    r_e = exp_r.pop_front();
                    check("rdata", rdata, r_e.data);
                    check("rid", {48'd0, rid}, {48'd0, r_e.id});
                    check("rresp", {62'd0, rresp}, {62'd0, r_e.resp});
                    check("rlast", {63'd0, rlast}, {63'd0, r_e.last});
                end
            end
            hold_pend = rvalid && !rready;
            hold_data = rdata;
            hold_id   = rid;
            hold_resp = rresp;
            hold_last = rlast;
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic do_write(input logic [31:0] addr, input logic [15:0] id,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] strb,
                            input logic [1:0] exp_resp, input bit bad_last);
        int n;
        b_exp_t e;
        e.id = id;
        e.resp = exp_resp;
        exp_b.push_back(e);
        awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_handshake", {63'd0, awready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = strb;
            wlast  = bad_last ? (i == 0) : (i == int'(len));
            n = 0;
            @(negedge clk);
            while (!wready && n < 50) begin @(negedge clk); n++; end
            check("w_handshake", {63'd0, wready}, 64'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        n = 0;
        while (exp_b.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        check("b_drain", 64'(exp_b.size()), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [15:0] id,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit stall);
        int n;
        araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_handshake", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("r_latency", {63'd0, rvalid}, 64'd1);
        n = 0;
        while (exp_r.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            if (stall) rready = ~rready;
            n++;
        end
        rready = 1'b1;
        check("r_drain", 64'(exp_r.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {63'd0, awready}, 64'd0);
        check("rst_arready", {63'd0, arready}, 64'd0);
        check("rst_wready",  {63'd0, wready},  64'd0);
        check("rst_bvalid",  {63'd0, bvalid},  64'd0);
        check("rst_rvalid",  {63'd0, rvalid},  64'd0);
        check("rst_rlast",   {63'd0, rlast},   64'd0);
        check("rst_resp",    {60'd0, bresp, rresp}, 64'd0);
        check("rst_ids",     {32'd0, bid, rid}, 64'd0);
        check("rst_rdata",   rdata, 64'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arready_pre_edge", {63'd0, arready}, 64'd0);
        @(posedge clk); #1;
        check("awready_first_edge", {63'd0, awready}, 64'd1);
        check("arready_first_edge", {63'd0, arready}, 64'd1);

        // INCR write/read-back
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        do_write(32'h8000_0000, 16'h1234, 8'd3, 3'd3, 2'b01, 8'hFF, 2'b00, 1'b0);
        wd[0] = 64'h55; wd[1] = 64'h66; wd[2] = 64'h77; wd[3] = 64'h88;
        do_write(32'h8000_0020, 16'h1235, 8'd3, 3'd3, 2'b01, 8'hFF, 2'b00, 1'b0);
        push_r(64'h11, 16'h0AB1, 2'b00, 1'b0);
        push_r(64'h22, 16'h0AB1, 2'b00, 1'b0);
        push_r(64'h33, 16'h0AB1, 2'b00, 1'b0);
        push_r(64'h44, 16'h0AB1, 2'b00, 1'b1);
        do_read(32'h8000_0000, 16'h0AB1, 8'd3, 3'd3, 2'b01, 1'b0);

        // partial strobe
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(32'h8000_0100, 16'h0002, 8'd0, 3'd3, 2'b01, 8'hFF, 2'b00, 1'b0);
        wd[0] = 64'h0;
        do_write(32'h8000_0100, 16'h0003, 8'd0, 3'd3, 2'b01, 8'h0F, 2'b00, 1'b0);
        push_r(64'hFFFF_FFFF_0000_0000, 16'h0004, 2'b00, 1'b1);
        do_read(32'h8000_0100, 16'h0004, 8'd0, 3'd3, 2'b01, 1'b0);

        // R backpressure over an 8-beat burst
        for (int i = 0; i < 8; i++)
            push_r(64'h11 * 64'(i + 1), 16'h0BB0, 2'b00, i == 7);
        do_read(32'h8000_0000, 16'h0BB0, 8'd7, 3'd3, 2'b01, 1'b1);

        // FIXED burst repeats one word
        push_r(64'h22, 16'h0005, 2'b00, 1'b0);
        push_r(64'h22, 16'h0005, 2'b00, 1'b1);
        do_read(32'h8000_0008, 16'h0005, 8'd1, 3'd3, 2'b00, 1'b0);

        // top-of-memory boundary and out of range
        wd[0] = 64'hDEAD_BEEF_0000_0001;
        do_write(32'h8000_7FF8, 16'h0006, 8'd0, 3'd3, 2'b01, 8'hFF, 2'b00, 1'b0);
        push_r(64'hDEAD_BEEF_0000_0001, 16'h0007, 2'b00, 1'b0);
        push_r(64'h0, 16'h0007, 2'b10, 1'b1);
        do_read(32'h8000_7FF8, 16'h0007, 8'd1, 3'd3, 2'b01, 1'b0);
        push_r(64'h0, 16'h0008, 2'b10, 1'b1);
        do_read(32'h8000_8000, 16'h0008, 8'd0, 3'd3, 2'b01, 1'b0);
        wd[0] = 64'h1234;
        do_write(32'h8000_8000, 16'h0009, 8'd0, 3'd3, 2'b01, 8'hFF, 2'b10, 1'b0);

        // oversize beat must not write
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(32'h8000_0000, 16'h000A, 8'd0, 3'd4, 2'b01, 8'hFF, 2'b10, 1'b0);
        push_r(64'h11, 16'h000B, 2'b00, 1'b1);
        do_read(32'h8000_0000, 16'h000B, 8'd0, 3'd3, 2'b01, 1'b0);

        // wlast mismatch flags error but in-range beats still write
        wd[0] = 64'hA0; wd[1] = 64'hB0;
        do_write(32'h8000_0200, 16'h000C, 8'd1, 3'd3, 2'b01, 8'hFF, 2'b10, 1'b1);
        push_r(64'hA0, 16'h000D, 2'b00, 1'b0);
        push_r(64'hB0, 16'h000D, 2'b00, 1'b1);
        do_read(32'h8000_0200, 16'h000D, 8'd1, 3'd3, 2'b01, 1'b0);

        // WRAP len 3 from 0x18
`ifdef AXI4_SRAM_WRAP_EN
        push_r(64'h44, 16'h000E, 2'b00, 1'b0);
        push_r(64'h11, 16'h000E, 2'b00, 1'b0);
        push_r(64'h22, 16'h000E, 2'b00, 1'b0);
        push_r(64'h33, 16'h000E, 2'b00, 1'b1);
`else
        push_r(64'h44, 16'h000E, 2'b10, 1'b0);
        push_r(64'h55, 16'h000E, 2'b10, 1'b0);
        push_r(64'h66, 16'h000E, 2'b10, 1'b0);
        push_r(64'h77, 16'h000E, 2'b10, 1'b1);
`endif
        do_read(32'h8000_0018, 16'h000E, 8'd3, 3'd3, 2'b10, 1'b0);

        // WRAP with illegal length, and reserved burst: INCR with SLVERR
        push_r(64'h22, 16'h000F, 2'b10, 1'b0);
        push_r(64'h33, 16'h000F, 2'b10, 1'b0);
        push_r(64'h44, 16'h000F, 2'b10, 1'b1);
        do_read(32'h8000_0008, 16'h000F, 8'd2, 3'd3, 2'b10, 1'b0);
        push_r(64'h11, 16'h0010, 2'b10, 1'b0);
        push_r(64'h22, 16'h0010, 2'b10, 1'b1);
        do_read(32'h8000_0000, 16'h0010, 8'd1, 3'd3, 2'b11, 1'b0);

        // reset while beat 2 of an 8-beat read is presented
        for (int i = 0; i < 8; i++)
            push_r(64'h11 * 64'(i + 1), 16'h0777, 2'b00, i == 7);
        araddr = 32'h8000_0000; arid = 16'h0777; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_handshake_rst", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (exp_r.size() > 7 && n < 50) begin @(posedge clk); #1; n++; end
        check("rst_burst_progress", 64'(exp_r.size()), 64'd7);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_mid_rlast", {63'd0, rlast}, 64'd0);
        check("rst_mid_arready", {63'd0, arready}, 64'd0);
        exp_r.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("arready_after_rst", {63'd0, arready}, 64'd1);
        push_r(64'h11, 16'h0888, 2'b00, 1'b1);
        do_read(32'h8000_0000, 16'h0888, 8'd0, 3'd3, 2'b01, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
